cpu_dmem_responder: RTL and testbench
=====================================

CPU_DMEM_RESPONDER -- requirements
Module: cpu_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit data RAM words (power of two).
REQ-002 SHALL have parameter MMIO_BASE, default 16'hFFFF, value of addr[31:16] that selects MMIO space.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port cpu_rw_addr, input, 32, CPU byte address.
REQ-006 SHALL have port cpu_rw, input, 2, CPU request: bit1 = request valid, bit0 = 1 read / 0 write.
REQ-007 SHALL have port cpu_wr_data, input, 32, CPU write data.
REQ-008 SHALL have port cpu_rd_data, output, 32, read data returned to the CPU.
REQ-009 SHALL have port cpu_rw_vld, output, 1, single-cycle completion pulse.
REQ-010 SHALL have port cpu_err, output, 1, misaligned-access flag, qualified by cpu_rw_vld.
REQ-011 SHALL have port pwm_data, output, 32, PWM duty register.
REQ-012 SHALL have port timer_data, output, 32, timer period register.
REQ-013 SHALL have port timer_clr, output, 1, single-cycle timer clear pulse.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-015 In IDLE with cpu_rw[1]=1, SHALL register addr, rw and data, then go to ACCESS.
REQ-016 Region decode: addr[31:16]==MMIO_BASE selects MMIO; all other addresses select RAM.
REQ-017 In ACCESS, a RAM read SHALL register ram[addr[log2(DEPTH_WORDS)+1:2]]; upper address bits are ignored (addresses wrap).
REQ-018 In ACCESS, a RAM write SHALL store the captured data at the same index.
REQ-019 MMIO offset 0x0 = pwm_data (R/W); 0x4 = timer_data (R/W).
REQ-020 MMIO offset 0x8 = timer_clr: a write pulses timer_clr high for exactly the ACCESS cycle; a read returns 0.
REQ-021 Unmapped MMIO offsets: reads return 0, writes have no effect, completion still occurs.
REQ-022 In RESP, SHALL assert cpu_rw_vld for exactly one cycle, with cpu_rd_data holding the read result; cpu_rd_data SHALL be 0 for writes.
REQ-023 Latency: request seen at edge N, cpu_rw_vld high during cycle N+2; next request accepted no earlier than the IDLE cycle after RESP.
REQ-024 cpu_rw SHALL be ignored in ACCESS and RESP; the CPU holds the request until cpu_rw_vld, and a held request is not re-accepted in the same transaction.
REQ-025 cpu_rd_data SHALL hold its last value outside RESP.

Reset
REQ-026 On rst, SHALL force state=IDLE and cpu_rw_vld, cpu_err, timer_clr=0.
REQ-027 On rst, SHALL clear cpu_rd_data, pwm_data and timer_data to 0.
REQ-028 Reset mid-transaction SHALL abort it with no completion pulse; RAM contents are not reset.

Configuration
REQ-029 With DMEM_ALIGN_CHK_EN defined, an access with addr[1:0]!=0 SHALL perform no RAM/MMIO side effect and complete with cpu_err=1 and cpu_rd_data=0 at normal latency.
REQ-030 Without DMEM_ALIGN_CHK_EN, addr[1:0] is ignored and cpu_err is tied 0.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the state enum, MMIO offsets and MMIO_BASE default.
REQ-032 RAM SHALL be a sub-module dmem_ram: single-port, synchronous read/write, one-cycle read latency.

Verification
REQ-033 Write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> vld two cycles after each request, rd_data=0xDEADBEEF.
REQ-034 Write 0x00000080 to 0xFFFF0000 -> pwm_data=0x80 after ACCESS; read back -> 0x80.
REQ-035 Write to 0xFFFF0008 -> timer_clr high exactly one cycle; read -> 0; read 0xFFFF00F0 -> 0, vld asserted.
REQ-036 Assert rst during ACCESS of a write -> no vld, state IDLE, pwm/timer=0; re-issue completes normally.
REQ-037 With DMEM_ALIGN_CHK_EN, write 0x12345678 to 0x00000013 -> vld with cpu_err=1; read 0x00000010 -> previous value unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the CPU data-memory responder: FSM states, MMIO map, defaults.
// No logic, so no latency. No flow control.
// MMIO offsets are byte offsets within the 64 KiB window selected by addr[31:16].
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [15:0] MMIO_BASE_DEF = 16'hFFFF;

    localparam logic [15:0] OFS_PWM   = 16'h0000;
    localparam logic [15:0] OFS_TIMER = 16'h0004;
    localparam logic [15:0] OFS_TCLR  = 16'h0008;

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM with a synchronous read and a synchronous write.
// Latency: read data is registered one cycle after en. No flow control.
// A write cycle also updates rdata, with the word's old contents.
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cpu_dmem_responder.sv
// CPU data-memory responder: RAM plus PWM/timer MMIO. DMEM_ALIGN_CHK_EN rejects misaligned accesses.
// Latency: request accepted at edge N, cpu_rw_vld pulses in the cycle after edge N+2.
// Backpressure: one transaction at a time. The CPU holds cpu_rw until it sees cpu_rw_vld.
module cpu_dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [15:0] MMIO_BASE   = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_rw_addr,
    input  logic [1:0]  cpu_rw,
    input  logic [31:0] cpu_wr_data,
    output logic [31:0] cpu_rd_data,
    output logic        cpu_rw_vld,
    output logic        cpu_err,
    output logic [31:0] pwm_data,
    output logic [31:0] timer_data,
    output logic        timer_clr
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state;
    logic [31:2] addr_q;
    logic        rd_q;
    logic [31:0] wdat_q;
    logic        misal_q;

    logic        misal_in;
    logic        accept;
    logic        tclr_hit;
    logic        acc_mmio;
    logic [15:0] acc_ofs;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata;
    logic [31:0] resp_data;

`ifdef DMEM_ALIGN_CHK_EN
    assign misal_in = |cpu_rw_addr[1:0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_rw_addr[1:0];
    assign misal_in        = 1'b0;
`endif

    // The vld cycle is already IDLE; blocking it stops a still-held request from being taken twice.
    assign accept = (state == ST_IDLE) && cpu_rw[1] && !cpu_rw_vld;

    // Decoded from the live inputs so the pulse lines up with the ACCESS cycle.
    assign tclr_hit = !cpu_rw[0] && !misal_in
                    && (cpu_rw_addr[31:16] == MMIO_BASE)
                    && ({cpu_rw_addr[15:2], 2'b00} == OFS_TCLR);

    assign acc_mmio = (addr_q[31:16] == MMIO_BASE);
    assign acc_ofs  = {addr_q[15:2], 2'b00};
    assign ram_en   = (state == ST_ACCESS) && !acc_mmio && !misal_q;
    assign ram_we   = ram_en && !rd_q;

    always_comb begin
        mmio_rdata = '0;
        case (acc_ofs)
            OFS_PWM:   mmio_rdata = pwm_data;
            OFS_TIMER: mmio_rdata = timer_data;
            default:   mmio_rdata = '0;
        endcase
    end

    always_comb begin
        resp_data = '0;
        if (rd_q && !misal_q) begin
            resp_data = acc_mmio ? mmio_rdata : ram_rdata;
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdat_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            wdat_q      <= '0;
            misal_q     <= 1'b0;
            cpu_rd_data <= '0;
            cpu_rw_vld  <= 1'b0;
            cpu_err     <= 1'b0;
            pwm_data    <= '0;
            timer_data  <= '0;
            timer_clr   <= 1'b0;
        end else begin
            cpu_rw_vld <= 1'b0;
            cpu_err    <= 1'b0;
            timer_clr  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q    <= cpu_rw_addr[31:2];
                        rd_q      <= cpu_rw[0];
                        wdat_q    <= cpu_wr_data;
                        misal_q   <= misal_in;
                        timer_clr <= tclr_hit;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (acc_mmio && !rd_q && !misal_q) begin
                        case (acc_ofs)
                            OFS_PWM:   pwm_data   <= wdat_q;
                            OFS_TIMER: timer_data <= wdat_q;
                            default:   ;
                        endcase
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    cpu_rw_vld  <= 1'b1;
                    cpu_err     <= misal_q;
                    cpu_rd_data <= resp_data;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Self-checking bench for cpu_dmem_responder: vector table plus reset-abort sequence.
// Expected read data/err go into a queue at issue time and are popped on each cpu_rw_vld.
module tb_cpu_dmem_responder;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_pwm;
        logic [31:0] exp_timer;
        int          exp_tclr;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_rw_addr;
    logic [1:0]  cpu_rw;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        cpu_rw_vld;
    logic        cpu_err;
    logic [31:0] pwm_data;
    logic [31:0] timer_data;
    logic        timer_clr;

    int    n_vec  = 0;
    int    n_miss = 0;
    int    tclr_cnt = 0;
    int    vld_cnt  = 0;
    resp_t exp_q[$];
    vec_t  vecs[$];

    always #5 clk = ~clk;

    cpu_dmem_responder #(
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (16'hFFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_rw_addr (cpu_rw_addr),
        .cpu_rw      (cpu_rw),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rd_data (cpu_rd_data),
        .cpu_rw_vld  (cpu_rw_vld),
        .cpu_err     (cpu_err),
        .pwm_data    (pwm_data),
        .timer_data  (timer_data),
        .timer_clr   (timer_clr)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Scoreboard side: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (timer_clr) tclr_cnt++;
        if (cpu_rw_vld) vld_cnt++;
        if (!rst && cpu_rw_vld) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_vld: got vld with no outstanding request, want none");
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("rd_data", cpu_rd_data, e.rd);
                check("err", {31'b0, cpu_err}, {31'b0, e.err});
            end
        end
    end

    // One CPU transaction; request stays asserted through the edge at which vld is seen.
    task automatic do_access(input vec_t v);
        int cyc;
        int t0;
        t0 = tclr_cnt;
        exp_q.push_back('{rd: v.exp_rd, err: v.exp_err});
        cpu_rw_addr = v.addr;
        cpu_wr_data = v.wdat;
        cpu_rw      = {1'b1, v.rd};
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (!cpu_rw_vld && cyc < 20);
        check("latency", cyc, 3);
        if (!cpu_rw_vld) exp_q.delete();
        @(posedge clk);
        #1 cpu_rw = 2'b00;
        @(negedge clk);
        check("vld_single", {31'b0, cpu_rw_vld}, 32'd0);
        check("rd_hold", cpu_rd_data, v.exp_rd);
        check("pwm", pwm_data, v.exp_pwm);
        check("timer", timer_data, v.exp_timer);
        check("tclr_pulses", tclr_cnt - t0, v.exp_tclr);
    endtask

    function automatic vec_t mk(input logic rd, input logic [31:0] addr, input logic [31:0] wdat,
                                input logic [31:0] exp_rd, input logic exp_err,
                                input logic [31:0] exp_pwm, input logic [31:0] exp_timer,
                                input int exp_tclr);
        vec_t v;
        v.rd = rd; v.addr = addr; v.wdat = wdat; v.exp_rd = exp_rd; v.exp_err = exp_err;
        v.exp_pwm = exp_pwm; v.exp_timer = exp_timer; v.exp_tclr = exp_tclr;
        return v;
    endfunction

    initial begin
        int v0;
        rst         = 1'b1;
        cpu_rw      = 2'b00;
        cpu_rw_addr = '0;
        cpu_wr_data = '0;

        // rd, addr, wdata, exp_rd, exp_err, exp_pwm, exp_timer, exp_tclr
        vecs.push_back(mk(0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 32'h0,  32'h0,    0));
        vecs.push_back(mk(1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 32'h0,  32'h0,    0));
        vecs.push_back(mk(0, 32'hFFFF_0000, 32'h0000_0080, 32'h0,         0, 32'h80, 32'h0,    0));
        vecs.push_back(mk(1, 32'hFFFF_0000, 32'h0,         32'h80,        0, 32'h80, 32'h0,    0));
        vecs.push_back(mk(0, 32'hFFFF_0004, 32'h0000_1234, 32'h0,         0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(1, 32'hFFFF_0004, 32'h0,         32'h1234,      0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(0, 32'hFFFF_0008, 32'hFFFF_FFFF, 32'h0,         0, 32'h80, 32'h1234, 1));
        vecs.push_back(mk(1, 32'hFFFF_0008, 32'h0,         32'h0,         0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(1, 32'hFFFF_00F0, 32'h0,         32'h0,         0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(0, 32'hFFFF_00F0, 32'h0000_AAAA, 32'h0,         0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(0, 32'h0000_0014, 32'hCAFE_F00D, 32'h0,         0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(1, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(0, 32'h0000_1018, 32'h600D_600D, 32'h0,         0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(1, 32'h0000_0018, 32'h0,         32'h600D_600D, 0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(0, 32'hFFFE_0000, 32'h0BAD_F00D, 32'h0,         0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(1, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 0, 32'h80, 32'h1234, 0));
        vecs.push_back(mk(1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 32'h80, 32'h1234, 0));

        repeat (2) @(negedge clk);
        check("rst_rd_data", cpu_rd_data, 32'h0);
        check("rst_vld", {31'b0, cpu_rw_vld}, 32'h0);
        check("rst_err", {31'b0, cpu_err}, 32'h0);
        check("rst_pwm", pwm_data, 32'h0);
        check("rst_timer", timer_data, 32'h0);
        check("rst_tclr", {31'b0, timer_clr}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            do_access(vecs[i]);
        end

        // Reset lands in the ACCESS cycle of a PWM write: no completion, registers cleared.
        v0 = vld_cnt;
        cpu_rw_addr = 32'hFFFF_0000;
        cpu_wr_data = 32'h0000_0055;
        cpu_rw      = 2'b10;
        @(posedge clk);
        #1 rst = 1'b1;
        cpu_rw = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_vld", vld_cnt - v0, 0);
        check("abort_pwm", pwm_data, 32'h0);
        check("abort_timer", timer_data, 32'h0);
        check("abort_rd_data", cpu_rd_data, 32'h0);
        do_access(mk(0, 32'hFFFF_0000, 32'h0000_0055, 32'h0,         0, 32'h55, 32'h0, 0));
        do_access(mk(1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 32'h55, 32'h0, 0));

`ifdef DMEM_ALIGN_CHK_EN
        do_access(mk(0, 32'h0000_0013, 32'h1234_5678, 32'h0,         1, 32'h55, 32'h0, 0));
        do_access(mk(1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 32'h55, 32'h0, 0));
        do_access(mk(1, 32'hFFFF_0001, 32'h0,         32'h0,         1, 32'h55, 32'h0, 0));
        do_access(mk(0, 32'hFFFF_0009, 32'h0,         32'h0,         1, 32'h55, 32'h0, 0));
        do_access(mk(0, 32'hFFFF_0002, 32'h0000_0099, 32'h0,         1, 32'h55, 32'h0, 0));
`else
        do_access(mk(0, 32'h0000_0013, 32'h1234_5678, 32'h0,         0, 32'h55, 32'h0, 0));
        do_access(mk(1, 32'h0000_0010, 32'h0,         32'h1234_5678, 0, 32'h55, 32'h0, 0));
        do_access(mk(1, 32'hFFFF_0001, 32'h0,         32'h55,        0, 32'h55, 32'h0, 0));
`endif

        repeat (8) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
